// File: rtl/reg8_display_scan_pkg.sv
// Shared constants for the register-file display scanner: digit count, idle patterns
// and the active-low hex glyph table used by the segment decoder.
package reg8_display_scan_pkg;

   localparam int NUM_DIGITS = 8;
   localparam int IDX_W      = 3;
   localparam int SEG_W      = 8;
   localparam int GLYPH_W    = 7;

   typedef logic [IDX_W-1:0] idx_t;

   localparam logic [SEG_W-1:0]      SEG_OFF  = 8'hFF;
   localparam logic [NUM_DIGITS-1:0] EN_OFF   = 8'hFF;
   localparam idx_t                  LAST_IDX = 3'd7;

   // {g,f,e,d,c,b,a}, active-low; element [n] is the glyph for hex digit n
   localparam logic [15:0][GLYPH_W-1:0] HEX7_GLYPH = {
      7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
      7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
      7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
      7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
   };

endpackage

// File: rtl/reg8_display_scan_if.sv
// Link between the scanner (master) and the register file / display side (slave).
interface reg8_display_scan_if;
   import reg8_display_scan_pkg::*;

   logic                  page;
   logic [7:0]            q;
   logic [IDX_W-1:0]      rsel;
   logic [NUM_DIGITS-1:0] led_en;
   logic [SEG_W-1:0]      seg;

   modport master (input page, input q, output rsel, output led_en, output seg);
   modport slave  (output page, output q, input rsel, input led_en, input seg);

endinterface

// File: rtl/reg8_display_scan_seg7_hex_decode.sv
// Pure combinational nibble to active-low seven-segment glyph decoder.
module seg7_hex_decode
   import reg8_display_scan_pkg::*;
(
   input  logic [3:0]         nib_i,
   output logic [GLYPH_W-1:0] seg_n_o
);

   assign seg_n_o = HEX7_GLYPH[nib_i];

endmodule

// File: rtl/reg8_display_scan.sv
// Scans the 8x8 register file onto an 8-digit common-anode display, one hex digit per register.
// Defining SCAN_BLANK_EN blanks the first BLANK_CYC cycles of every slot to suppress ghosting.
module reg8_display_scan
   import reg8_display_scan_pkg::*;
#(
   parameter int SCAN_DIV  = 100000,
   parameter int BLANK_CYC = 1000
) (
   input  logic                clk,
   input  logic                clr_n,
   reg8_display_scan_if.master bus
);

   localparam int CNT_W = $clog2(SCAN_DIV);

`ifdef SCAN_BLANK_EN
   localparam int BLANK_LEN = BLANK_CYC;
`else
   localparam int BLANK_LEN = 0 * BLANK_CYC;
`endif

   logic [CNT_W-1:0]      div_cnt_q, div_cnt_d;
   idx_t                  idx_q, idx_d;
   logic [NUM_DIGITS-1:0] led_en_q, led_en_d;
   logic [SEG_W-1:0]      seg_q, seg_d;

   logic                  tick_s;
   logic                  blank_s;
   logic                  dp_n_s;
   logic [3:0]            nib_s;
   logic [GLYPH_W-1:0]    glyph_s;

   seg7_hex_decode u_dec (
      .nib_i   (nib_s),
      .seg_n_o (glyph_s)
   );

   // Slot divider and digit index: the index advances on the divider wrap cycle
   always_comb begin
      tick_s = (div_cnt_q == CNT_W'(SCAN_DIV - 1));
      if (tick_s) begin
         div_cnt_d = '0;
         idx_d     = idx_q + 3'd1;
      end else begin
         div_cnt_d = div_cnt_q + CNT_W'(1);
         idx_d     = idx_q;
      end
   end

   // Next display pattern; q is already the data for rsel == idx_q in this cycle
   always_comb begin
      nib_s   = bus.page ? bus.q[7:4] : bus.q[3:0];
      dp_n_s  = ~(bus.page && (idx_q == LAST_IDX));
      blank_s = (int'(div_cnt_q) < BLANK_LEN);
      if (blank_s) begin
         led_en_d = EN_OFF;
         seg_d    = SEG_OFF;
      end else begin
         led_en_d = ~(8'b1 << idx_q);
         seg_d    = {dp_n_s, glyph_s};
      end
   end

   // State and output registers, all cleared by the asynchronous reset
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         div_cnt_q <= '0;
         idx_q     <= 3'd0;
         led_en_q  <= EN_OFF;
         seg_q     <= SEG_OFF;
      end else begin
         div_cnt_q <= div_cnt_d;
         idx_q     <= idx_d;
         led_en_q  <= led_en_d;
         seg_q     <= seg_d;
      end
   end

   assign bus.rsel   = idx_q;
   assign bus.led_en = led_en_q;
   assign bus.seg    = seg_q;

endmodule

// File: tb/tb_reg8_display_scan.sv
// Directed scoreboard bench for reg8_display_scan with an inline 8x8 register file model.
module tb_reg8_display_scan;

   localparam int SCAN_DIV  = 8;
   localparam int BLANK_CYC = 2;

   localparam logic [6:0] GLYPH [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
   };

   logic       clk;
   logic       clr_n;
   logic       wr_en;
   logic [2:0] wsel;
   logic [7:0] wd;
   logic [7:0] rf [8];

   int         total = 0;
   int         bad   = 0;
   int         cnt_m = 0;
   logic [2:0] idx_m = 3'd0;
   logic [15:0] sb_q [$];

   reg8_display_scan_if bus ();

   reg8_display_scan #(
      .SCAN_DIV  (SCAN_DIV),
      .BLANK_CYC (BLANK_CYC)
   ) dut (
      .clk   (clk),
      .clr_n (clr_n),
      .bus   (bus.master)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Register file: synchronous write, asynchronous read
   always @(posedge clk) begin
      if (wr_en) rf[wsel] <= wd;
   end
   assign bus.q = rf[bus.rsel];

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock: predict the registered outputs, push, clock, pop and compare
   task automatic step();
      logic [7:0]  row;
      logic [3:0]  nib;
      logic        blank;
      logic [7:0]  el;
      logic [7:0]  es;
      logic [15:0] e;
      row   = rf[idx_m];
      nib   = bus.page ? row[7:4] : row[3:0];
      blank = 1'b0;
`ifdef SCAN_BLANK_EN
      blank = (cnt_m < BLANK_CYC);
`endif
      el = blank ? 8'hFF : ~(8'b1 << idx_m);
      es = blank ? 8'hFF : {~(bus.page && (idx_m == 3'd7)), GLYPH[nib]};
      sb_q.push_back({el, es});
      @(posedge clk);
      #1;
      if (cnt_m == SCAN_DIV - 1) idx_m = idx_m + 3'd1;
      cnt_m = (cnt_m + 1) % SCAN_DIV;
      e = sb_q.pop_front();
      chk("led_en", bus.led_en, e[15:8]);
      chk("seg", bus.seg, e[7:0]);
      chk("rsel", {5'd0, bus.rsel}, {5'd0, idx_m});
   endtask

   task automatic run_until(input int idx, input int cnt);
      int n;
      n = 0;
      while (!((int'(idx_m) == idx) && (cnt_m == cnt)) && (n < 200)) begin
         step();
         n++;
      end
      total++;
      assert ((int'(idx_m) == idx) && (cnt_m == cnt)) else begin
         bad++;
         $error("FAIL run_until: observed idx=%0d cnt=%0d expected idx=%0d cnt=%0d",
                idx_m, cnt_m, idx, cnt);
      end
   endtask

   initial begin
      logic [2:0] prev;
      int         t01 [2];
      int         n01;
      int         vis4;
      int         wrap_seen;

      clr_n    = 1'b0;
      bus.page = 1'b0;
      wr_en    = 1'b0;
      wsel     = 3'd0;
      wd       = 8'h00;

      // Reset held while the register file is preloaded with 8'h11*i
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         wr_en = 1'b1;
         wsel  = 3'(i);
         wd    = 8'(8'h11 * i);
      end
      @(posedge clk);
      #1;
      wr_en = 1'b0;
      chk("rst_led_en", bus.led_en, 8'hFF);
      chk("rst_seg", bus.seg, 8'hFF);
      chk("rst_rsel", {5'd0, bus.rsel}, 8'd0);

      // Scan: every slot, wrap, period and tick latency
      clr_n     = 1'b1;
      cnt_m     = 0;
      idx_m     = 3'd0;
      n01       = 0;
      vis4      = 0;
      wrap_seen = 0;
      t01[0]    = 0;
      t01[1]    = 0;
      for (int s = 1; s <= 80; s++) begin
         prev = bus.rsel;
         step();
         if (bus.led_en == 8'hEF) vis4++;
         if (bus.rsel != prev) begin
            chk("tick_latency", bus.led_en, ~(8'b1 << prev));
            if (prev == 3'd7 && bus.rsel == 3'd0) wrap_seen = 1;
            if (prev == 3'd0 && bus.rsel == 3'd1 && n01 < 2) begin
               t01[n01] = s;
               n01++;
            end
         end
      end
      chk("wrap_7_to_0", 8'(wrap_seen), 8'd1);
      chk("period", 8'(t01[1] - t01[0]), 8'd64);
`ifdef SCAN_BLANK_EN
      chk("visible_cycles", 8'(vis4), 8'd6);
`else
      chk("visible_cycles", 8'(vis4), 8'd8);
`endif

      // Page select: reg3 = A5, upper nibble mid-slot, decimal point on digit 7
      wr_en = 1'b1;
      wsel  = 3'd3;
      wd    = 8'hA5;
      step();
      wr_en = 1'b0;
      run_until(3, 4);
      chk("slot3_lo", {1'b0, bus.seg[6:0]}, {1'b0, GLYPH[5]});
      bus.page = 1'b1;
      step();
      chk("page_hi_A", {1'b0, bus.seg[6:0]}, 8'h08);
      chk("dp_slot3", {7'd0, bus.seg[7]}, 8'd1);
      run_until(7, 4);
      step();
      chk("dp_lit", {7'd0, bus.seg[7]}, 8'd0);
      bus.page = 1'b0;
      step();
      chk("dp_off", {7'd0, bus.seg[7]}, 8'd1);

      // Live write of reg2 during slot 5 shows on the next visit of slot 2
      run_until(5, 3);
      wr_en = 1'b1;
      wsel  = 3'd2;
      wd    = 8'hFF;
      step();
      wr_en = 1'b0;
      run_until(2, 4);
      step();
      chk("live_write_F", {1'b0, bus.seg[6:0]}, 8'h0E);

      // Asynchronous reset mid-slot, no clock edge in between
      run_until(4, 5);
      clr_n = 1'b0;
      #2;
      chk("async_led_en", bus.led_en, 8'hFF);
      chk("async_seg", bus.seg, 8'hFF);
      chk("async_rsel", {5'd0, bus.rsel}, 8'd0);
      @(posedge clk);
      #1;
      clr_n = 1'b1;
      cnt_m = 0;
      idx_m = 3'd0;
      for (int s = 0; s < 16; s++) step();
      chk("sb_empty", 8'(sb_q.size()), 8'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
